// File: rtl/pin_keypad_encoder_if.sv
// Keypad-to-gate-controller bus for the PIN encoder.
// The master side is the keypad scanner (it drives the key signals) and the
// slave side is the encoder (it drives the PIN bus and the status pulses).
interface pin_keypad_encoder_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] P;
  logic       p_enter;
  logic [1:0] digit_count;
  logic       entry_timeout;

  modport master (
    output key_valid,
    output key_code,
    input  P,
    input  p_enter,
    input  digit_count,
    input  entry_timeout
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output P,
    output p_enter,
    output digit_count,
    output entry_timeout
  );
endinterface

// File: rtl/pin_keypad_encoder.sv
// PIN keypad encoder: turns up to two decimal key presses into an 8-bit binary
// PIN with a one-cycle p_enter strobe. A clear key, an enter key and an
// inactivity timeout that discards partial entries are also handled.
module pin_keypad_encoder #(
  parameter int       TIMEOUT_CYCLES = 1000,
  parameter bit [3:0] CLEAR_CODE     = 4'hA,
  parameter bit [3:0] ENTER_CODE     = 4'hB
) (
  input logic             clk,
  input logic             reset,
  pin_keypad_encoder_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    tens;
  logic [3:0]    units;
  logic [CW-1:0] idle_cnt;
  logic          key_prev;

  logic          accept;
  logic          is_digit;
  logic          is_clear;
  logic          is_enter;
  logic          legal_key;
  logic [7:0]    enter_value;

  // A press counts only on the rising edge of key_valid; illegal codes are
  // treated as if nothing was pressed, so they do not refresh the idle timer.
  always_comb begin
    accept    = bus.key_valid & ~key_prev;
    is_digit  = (bus.key_code <= 4'd9);
    is_clear  = (bus.key_code == CLEAR_CODE);
    is_enter  = (bus.key_code == ENTER_CODE);
    legal_key = accept & (is_digit | is_clear | is_enter);
  end

  // PIN value for the enter key: tens*10 + units, at most 99 so 8 bits suffice.
  always_comb begin
    enter_value = 8'd0;
    if (state == ONE) begin
      enter_value = {4'd0, units};
    end else begin
      enter_value = ({4'd0, tens} << 3) + ({4'd0, tens} << 1) + {4'd0, units};
    end
  end

  assign bus.digit_count = state;

  // Entry state machine, digit buffer, idle timer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= EMPTY;
      tens              <= 4'd0;
      units             <= 4'd0;
      idle_cnt          <= '0;
      key_prev          <= 1'b1;
      bus.P             <= 8'd0;
      bus.p_enter       <= 1'b0;
      bus.entry_timeout <= 1'b0;
    end else begin
      key_prev          <= bus.key_valid;
      bus.p_enter       <= 1'b0;
      bus.entry_timeout <= 1'b0;
      if (legal_key) begin
        idle_cnt <= '0;
        if (is_clear) begin
          tens  <= 4'd0;
          units <= 4'd0;
          state <= EMPTY;
        end else if (is_enter) begin
          if (state != EMPTY) begin
            bus.P       <= enter_value;
            bus.p_enter <= 1'b1;
            tens        <= 4'd0;
            units       <= 4'd0;
            state       <= EMPTY;
          end
        end else begin
          case (state)
            EMPTY: begin
              units <= bus.key_code;
              state <= ONE;
            end
            ONE, TWO: begin
              tens  <= units;
              units <= bus.key_code;
              state <= TWO;
            end
            default: begin
              tens  <= 4'd0;
              units <= 4'd0;
              state <= EMPTY;
            end
          endcase
        end
      end else if (state != EMPTY) begin
        if (idle_cnt == LAST_IDLE) begin
          tens              <= 4'd0;
          units             <= 4'd0;
          state             <= EMPTY;
          idle_cnt          <= '0;
          bus.entry_timeout <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule
